// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the data stage; DM has fixed priority.
// Latency: Ready two cycles after grant plus memory wait cycles; requests are held until Ready.
`timescale 1ns/1ps
module mem_port_arbiter #(
   parameter int ADDR_WIDTH = 30,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  IF_Read,
   input  logic [ADDR_WIDTH-1:0] IF_Address,
   output logic [31:0]           IF_DataOut,
   output logic                  IF_Ready,
   output logic                  IF_Error,
   input  logic                  DM_Read,
   input  logic [3:0]            DM_Write,
   input  logic [ADDR_WIDTH-1:0] DM_Address,
   input  logic [31:0]           DM_DataIn,
   output logic [31:0]           DM_DataOut,
   output logic                  DM_Ready,
   output logic                  DM_Error,
   output logic                  DM_Stall,
   output logic [ADDR_WIDTH-1:0] Mem_Address,
   output logic [31:0]           Mem_DataOut,
   output logic                  Mem_Read,
   output logic [3:0]            Mem_Write,
   input  logic [31:0]           Mem_DataIn,
   input  logic                  Mem_Ready
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // Watchdog compare value; TIMEOUT above 256 cannot be reached by the saturating counter.
   localparam logic [7:0] TO_LAST = 8'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   logic [1:0] state;
   logic       owner;
   logic [7:0] wd_cnt;
   logic       dm_req;
   logic       owner_req;
   logic       wd_expire;

   assign dm_req    = DM_Read | (|DM_Write);
   assign owner_req = owner ? dm_req : IF_Read;
   assign wd_expire = (TIMEOUT != 0) && (wd_cnt == TO_LAST);
   assign DM_Stall  = dm_req & ~DM_Ready;

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         owner       <= 1'b0;
         wd_cnt      <= 8'd0;
         Mem_Address <= '0;
         Mem_DataOut <= 32'd0;
         Mem_Read    <= 1'b0;
         Mem_Write   <= 4'd0;
         IF_DataOut  <= 32'd0;
         IF_Ready    <= 1'b0;
         IF_Error    <= 1'b0;
         DM_DataOut  <= 32'd0;
         DM_Ready    <= 1'b0;
         DM_Error    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (dm_req) begin
                  owner       <= 1'b1;
                  Mem_Address <= DM_Address;
                  Mem_DataOut <= DM_DataIn;
                  Mem_Write   <= DM_Write;
                  // A simultaneous read and write is serviced as the write alone.
                  Mem_Read    <= ~(|DM_Write);
                  wd_cnt      <= 8'd0;
                  state       <= BUSY;
               end else if (IF_Read) begin
                  owner       <= 1'b0;
                  Mem_Address <= IF_Address;
                  Mem_DataOut <= 32'd0;
                  Mem_Write   <= 4'd0;
                  Mem_Read    <= 1'b1;
                  wd_cnt      <= 8'd0;
                  state       <= BUSY;
               end
            end

            BUSY: begin
               if (Mem_Ready) begin
                  Mem_Read  <= 1'b0;
                  Mem_Write <= 4'd0;
                  state     <= DONE;
                  // A requester that withdrew (flush) gets neither Ready nor new data.
                  if (owner_req) begin
                     if (owner) begin
                        DM_Ready <= 1'b1;
                        DM_Error <= 1'b0;
                        if (Mem_Read) DM_DataOut <= Mem_DataIn;
                     end else begin
                        IF_Ready <= 1'b1;
                        IF_Error <= 1'b0;
                        if (Mem_Read) IF_DataOut <= Mem_DataIn;
                     end
                  end
               end else if (wd_expire) begin
                  Mem_Read  <= 1'b0;
                  Mem_Write <= 4'd0;
                  state     <= DONE;
                  if (owner_req) begin
                     if (owner) begin
                        DM_Ready <= 1'b1;
                        DM_Error <= 1'b1;
                     end else begin
                        IF_Ready <= 1'b1;
                        IF_Error <= 1'b1;
                     end
                  end
               end else if (wd_cnt != 8'hFF) begin
                  wd_cnt <= wd_cnt + 8'd1;
               end
            end

            DONE: begin
               IF_Ready <= 1'b0;
               IF_Error <= 1'b0;
               DM_Ready <= 1'b0;
               DM_Error <= 1'b0;
               state    <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed timing cases plus randomized IF/DM traffic
// against a transaction-level memory model, with a queue-based scoreboard.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   localparam int TO = 4;
   localparam logic [29:0] DMBASE = 30'h0010_0000;

   logic        clock = 1'b0;
   logic        reset;
   logic        IF_Read;
   logic [29:0] IF_Address;
   logic [31:0] IF_DataOut;
   logic        IF_Ready, IF_Error;
   logic        DM_Read;
   logic [3:0]  DM_Write;
   logic [29:0] DM_Address;
   logic [31:0] DM_DataIn, DM_DataOut;
   logic        DM_Ready, DM_Error, DM_Stall;
   logic [29:0] Mem_Address;
   logic [31:0] Mem_DataOut, Mem_DataIn;
   logic        Mem_Read, Mem_Ready;
   logic [3:0]  Mem_Write;

   mem_port_arbiter #(.ADDR_WIDTH(30), .TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset),
      .IF_Read(IF_Read), .IF_Address(IF_Address), .IF_DataOut(IF_DataOut),
      .IF_Ready(IF_Ready), .IF_Error(IF_Error),
      .DM_Read(DM_Read), .DM_Write(DM_Write), .DM_Address(DM_Address),
      .DM_DataIn(DM_DataIn), .DM_DataOut(DM_DataOut), .DM_Ready(DM_Ready),
      .DM_Error(DM_Error), .DM_Stall(DM_Stall),
      .Mem_Address(Mem_Address), .Mem_DataOut(Mem_DataOut), .Mem_Read(Mem_Read),
      .Mem_Write(Mem_Write), .Mem_DataIn(Mem_DataIn), .Mem_Ready(Mem_Ready)
   );

   always #5 clock = ~clock;

   typedef struct { logic [31:0] data; logic err; } exp_t;
   exp_t exp_if_q[$];
   exp_t exp_dm_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state: expected memory contents and last successful read per requester.
   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] dut_mem [logic [31:0]];
   logic [31:0] last_if = 32'd0;
   logic [31:0] last_dm = 32'd0;

   // Per-requester plan for how the memory answers the next access.
   int if_plan_wait = 0, dm_plan_wait = 0;
   bit if_plan_hang = 0, dm_plan_hang = 0;

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h3C5A_96E1;
   endfunction

   function automatic logic [31:0] ref_rd(input logic [29:0] a);
      return ref_mem.exists({2'b00, a}) ? ref_mem[{2'b00, a}] : init_word({2'b00, a});
   endfunction

   function automatic logic [31:0] dut_rd(input logic [29:0] a);
      return dut_mem.exists({2'b00, a}) ? dut_mem[{2'b00, a}] : init_word({2'b00, a});
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++)
         if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic if_issue(input logic [29:0] a, input int w, input bit hang, input bit track);
      exp_t e;
      if_plan_wait = w;
      if_plan_hang = hang;
      if (track) begin
         e.err  = hang;
         e.data = hang ? last_if : ref_rd(a);
         last_if = e.data;
         exp_if_q.push_back(e);
      end
      IF_Read    = 1'b1;
      IF_Address = a;
   endtask

   task automatic dm_issue(input bit rd, input logic [3:0] be, input logic [29:0] a,
                           input logic [31:0] d, input int w, input bit hang, input bit track);
      exp_t e;
      dm_plan_wait = w;
      dm_plan_hang = hang;
      if (track) begin
         e.err = hang;
         if (be != 4'd0) begin
            e.data = last_dm;
            if (!hang) ref_mem[{2'b00, a}] = merge(ref_rd(a), d, be);
         end else begin
            e.data  = hang ? last_dm : ref_rd(a);
            last_dm = e.data;
         end
         exp_dm_q.push_back(e);
      end
      DM_Read    = rd;
      DM_Write   = be;
      DM_Address = a;
      DM_DataIn  = d;
   endtask

   task automatic wait_if(input int budget, output int n);
      n = 0;
      do begin tick(); n++; end while (IF_Ready !== 1'b1 && n < budget);
      chk("if_ready_wait", IF_Ready, 1);
      IF_Read = 1'b0;
   endtask

   task automatic wait_dm(input int budget, output int n);
      n = 0;
      do begin tick(); n++; end while (DM_Ready !== 1'b1 && n < budget);
      chk("dm_ready_wait", DM_Ready, 1);
      DM_Read  = 1'b0;
      DM_Write = 4'd0;
   endtask

   // Memory: acks after the planned wait cycles, or never for a hang plan.
   initial begin
      bit active, hg;
      int wl;
      active = 0; hg = 0; wl = 0;
      Mem_Ready  = 1'b0;
      Mem_DataIn = 32'd0;
      forever begin
         @(negedge clock);
         if (reset || !(Mem_Read === 1'b1 || (|Mem_Write) === 1'b1)) begin
            active     = 0;
            Mem_Ready  = 1'b0;
            Mem_DataIn = $urandom;
         end else begin
            if (!active) begin
               active = 1;
               wl = Mem_Address[20] ? dm_plan_wait : if_plan_wait;
               hg = Mem_Address[20] ? dm_plan_hang : if_plan_hang;
            end
            if (!hg && wl == 0) begin
               Mem_Ready = 1'b1;
               if (Mem_Read) Mem_DataIn = dut_rd(Mem_Address);
               else begin
                  dut_mem[{2'b00, Mem_Address}] = merge(dut_rd(Mem_Address), Mem_DataOut, Mem_Write);
                  Mem_DataIn = $urandom;
               end
            end else begin
               Mem_Ready  = 1'b0;
               Mem_DataIn = $urandom;
               if (wl > 0) wl--;
            end
         end
      end
   end

   // Scoreboard monitor: every Ready pulse pops and checks the oldest expectation.
   logic prev_if_rdy = 1'b0, prev_dm_rdy = 1'b0;
   always @(negedge clock) begin
      exp_t e;
      if (reset) begin
         prev_if_rdy = 1'b0;
         prev_dm_rdy = 1'b0;
      end else begin
         if (IF_Ready === 1'b1) begin
            if (prev_if_rdy) chk("if_ready_pulse", {31'd0, prev_if_rdy & IF_Ready}, 0);
            if (exp_if_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL if_unexpected_ready: got ready, expected none outstanding");
            end else begin
               e = exp_if_q.pop_front();
               chk("if_data", IF_DataOut, e.data);
               chk("if_err", {31'd0, IF_Error}, {31'd0, e.err});
            end
         end
         if (DM_Ready === 1'b1) begin
            if (prev_dm_rdy) chk("dm_ready_pulse", {31'd0, prev_dm_rdy & DM_Ready}, 0);
            if (exp_dm_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL dm_unexpected_ready: got ready, expected none outstanding");
            end else begin
               e = exp_dm_q.pop_front();
               chk("dm_data", DM_DataOut, e.data);
               chk("dm_err", {31'd0, DM_Error}, {31'd0, e.err});
            end
         end
         prev_if_rdy = IF_Ready;
         prev_dm_rdy = DM_Ready;
      end
   end

   always @(negedge clock) begin
      #2;
      if (!reset) begin
         chk("dm_stall", {31'd0, DM_Stall}, {31'd0, (DM_Read | (|DM_Write)) & ~DM_Ready});
         chk("strobe_excl", {31'd0, Mem_Read & (|Mem_Write)}, 0);
      end
   end

   initial begin
      #500000;
      n_fail++;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "bench time limit exceeded");
   end

   initial begin
      int n;
      reset = 1'b1;
      IF_Read = 1'b0; IF_Address = '0;
      DM_Read = 1'b0; DM_Write = 4'd0; DM_Address = '0; DM_DataIn = 32'd0;
      ref_mem[32'h10] = 32'h2402_0005;
      dut_mem[32'h10] = 32'h2402_0005;
      repeat (3) tick();
      chk("rst_mem_read", {31'd0, Mem_Read}, 0);
      chk("rst_mem_write", {28'd0, Mem_Write}, 0);
      chk("rst_mem_addr", {2'b00, Mem_Address}, 0);
      chk("rst_if_ready", {31'd0, IF_Ready}, 0);
      chk("rst_dm_ready", {31'd0, DM_Ready}, 0);
      chk("rst_if_data", IF_DataOut, 0);
      chk("rst_dm_data", DM_DataOut, 0);
      reset = 1'b0;
      tick();

      // Single IF read, zero wait states.
      if_issue(30'h10, 0, 0, 1);
      tick();
      chk("t1_mem_read", {31'd0, Mem_Read}, 1);
      chk("t1_mem_addr", {2'b00, Mem_Address}, 32'h10);
      chk("t1_early_ready", {31'd0, IF_Ready}, 0);
      tick();
      chk("t1_if_ready", {31'd0, IF_Ready}, 1);
      chk("t1_if_data", IF_DataOut, 32'h2402_0005);
      IF_Read = 1'b0;
      tick();
      chk("t1_ready_drop", {31'd0, IF_Ready}, 0);

      // Simultaneous requests: DM first, IF granted the cycle after DM's Ready.
      if_issue(30'h11, 0, 0, 1);
      dm_issue(1, 4'd0, DMBASE | 30'd3, 32'd0, 0, 0, 1);
      #1 chk("t2_stall_c0", {31'd0, DM_Stall}, 1);
      tick();
      chk("t2_stall_c1", {31'd0, DM_Stall}, 1);
      chk("t2_dm_first", {2'b00, Mem_Address}, {2'b00, DMBASE | 30'd3});
      tick();
      chk("t2_dm_ready", {31'd0, DM_Ready}, 1);
      chk("t2_stall_c2", {31'd0, DM_Stall}, 0);
      chk("t2_if_waits", {31'd0, IF_Ready}, 0);
      DM_Read = 1'b0;
      tick();
      tick();
      chk("t2_if_addr_c4", {2'b00, Mem_Address}, 32'h11);
      tick();
      chk("t2_if_ready_c5", {31'd0, IF_Ready}, 1);
      IF_Read = 1'b0;
      tick();

      // Byte write with 3 wait cycles: ack lands on the last cycle before the watchdog.
      dm_issue(0, 4'b0011, DMBASE | 30'd5, 32'hDEAD_BEEF, 3, 0, 1);
      for (int c = 1; c <= 4; c++) begin
         tick();
         chk("t3_mem_write", {28'd0, Mem_Write}, 32'h3);
         chk("t3_no_ready", {31'd0, DM_Ready}, 0);
      end
      chk("t3_mem_wdata", Mem_DataOut, 32'hDEAD_BEEF);
      tick();
      chk("t3_dm_ready_c5", {31'd0, DM_Ready}, 1);
      chk("t3_dm_err", {31'd0, DM_Error}, 0);
      DM_Write = 4'd0;
      tick();
      dm_issue(1, 4'd0, DMBASE | 30'd5, 32'd0, 1, 0, 1);
      wait_dm(32, n);
      chk("t3_readback_latency", n, 3);
      tick();

      // Read+write conflict is a write.
      dm_issue(1, 4'hF, DMBASE | 30'd6, 32'h0BAD_F00D, 0, 0, 1);
      tick();
      chk("t4_mem_read", {31'd0, Mem_Read}, 0);
      chk("t4_mem_write", {28'd0, Mem_Write}, 32'hF);
      wait_dm(32, n);
      tick();
      dm_issue(1, 4'd0, DMBASE | 30'd6, 32'd0, 0, 0, 1);
      wait_dm(32, n);
      tick();

      // Watchdog: no acknowledge.
      if_issue(30'h12, 0, 1, 1);
      for (int c = 1; c <= TO; c++) begin
         tick();
         chk("t5_strobe_held", {31'd0, Mem_Read}, 1);
         chk("t5_no_ready", {31'd0, IF_Ready}, 0);
      end
      tick();
      chk("t5_strobe_drop", {31'd0, Mem_Read}, 0);
      chk("t5_if_ready", {31'd0, IF_Ready}, 1);
      chk("t5_if_err", {31'd0, IF_Error}, 1);
      IF_Read = 1'b0;
      tick();

      // Flush: IF withdraws during BUSY.
      if_issue(30'h13, 2, 0, 0);
      tick();
      IF_Read = 1'b0;
      tick();
      tick();
      tick();
      chk("t6_no_ready", {31'd0, IF_Ready}, 0);
      chk("t6_data_kept", IF_DataOut, last_if);
      tick();
      dm_issue(1, 4'd0, DMBASE | 30'd7, 32'd0, 0, 0, 1);
      tick();
      chk("t6_idle_regrant", {31'd0, Mem_Read}, 1);
      chk("t6_idle_addr", {2'b00, Mem_Address}, {2'b00, DMBASE | 30'd7});
      wait_dm(32, n);
      tick();

      // Reset during BUSY.
      dm_issue(0, 4'hC, DMBASE | 30'd8, 32'h1234_5678, 3, 0, 0);
      tick();
      chk("t7_busy", {28'd0, Mem_Write}, 32'hC);
      reset = 1'b1;
      DM_Write = 4'd0;
      tick();
      chk("t7_mem_write", {28'd0, Mem_Write}, 0);
      chk("t7_mem_addr", {2'b00, Mem_Address}, 0);
      chk("t7_mem_wdata", Mem_DataOut, 0);
      chk("t7_dm_ready", {31'd0, DM_Ready}, 0);
      chk("t7_dm_data", DM_DataOut, 0);
      chk("t7_if_data", IF_DataOut, 0);
      reset = 1'b0;
      last_if = 32'd0;
      last_dm = 32'd0;
      tick();

      // Randomized concurrent traffic.
      fork
         begin
            int m;
            for (int i = 0; i < 40; i++) begin
               repeat ($urandom_range(0, 3)) tick();
               if_issue(30'($urandom_range(0, 63)), $urandom_range(0, 3),
                        $urandom_range(0, 7) == 0, 1);
               wait_if(64, m);
            end
         end
         begin
            int m;
            int kind;
            logic [3:0] be;
            for (int i = 0; i < 40; i++) begin
               repeat ($urandom_range(0, 3)) tick();
               kind = $urandom_range(0, 2);
               be   = (kind == 0) ? 4'd0 : 4'($urandom_range(1, 15));
               dm_issue(kind != 1, be, DMBASE | 30'($urandom_range(0, 15)), $urandom,
                        $urandom_range(0, 3), $urandom_range(0, 7) == 0, 1);
               wait_dm(64, m);
            end
         end
      join
      repeat (4) tick();
      chk("if_queue_drained", exp_if_q.size(), 0);
      chk("dm_queue_drained", exp_dm_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single unified memory port between instruction fetch (IF) and the data memory stage (DM) of the 5-stage MIPS pipeline. It registers each granted request, drives the memory port until the memory acknowledges or a watchdog expires, then returns read data and a one-cycle Ready pulse to the winning requester. Its `IF_Ready` and `DM_Stall` outputs feed the hazard unit's `InstMem_Ready` and `MEM_Stall_Controller` inputs.

## Interface
- `ADDR_WIDTH`, default 30: word-address width.
- `TIMEOUT`, default 255: maximum cycles to wait for `Mem_Ready`; 0 disables the watchdog.
- `clock`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `IF_Read`  in  1: instruction read request; held until `IF_Ready`.
- `IF_Address`  in  ADDR_WIDTH: instruction word address.
- `IF_DataOut`  out  32: fetched instruction.
- `IF_Ready`  out  1: one-cycle completion pulse.
- `IF_Error`  out  1: valid with `IF_Ready`; set when the watchdog expired.
- `DM_Read`  in  1: data read request.
- `DM_Write`  in  4: byte-lane write enables. Any nonzero value is a write request.
- `DM_Address`  in  ADDR_WIDTH: data word address.
- `DM_DataIn`  in  32: store data.
- `DM_DataOut`  out  32: load data.
- `DM_Ready`  out  1: one-cycle completion pulse.
- `DM_Error`  out  1: valid with `DM_Ready`.
- `DM_Stall`  out  1: combinational, `(DM_Read | (|DM_Write)) & ~DM_Ready`.
- `Mem_Address`  out  ADDR_WIDTH: memory port address.
- `Mem_DataOut`  out  32: memory write data.
- `Mem_Read`  out  1: memory read strobe.
- `Mem_Write`  out  4: memory byte write enables.
- `Mem_DataIn`  in  32: memory read data.
- `Mem_Ready`  in  1: memory acknowledge. Sampled only in BUSY.

## Operation
- The FSM has three states: IDLE, BUSY, DONE. A 1-bit `owner` register holds 0 for IF and 1 for DM.
- **IDLE**
  - DM request pending: grant DM, whether or not IF is also requesting. DM has fixed priority because it is the older instruction.
  - Only IF pending: grant IF.
  - On grant, register address, write data and enables onto the `Mem_*` port, clear the watchdog counter, and go to BUSY.
  - No request: stay in IDLE with the `Mem_*` strobes low.
- **BUSY**
  - Hold the `Mem_*` outputs stable.
  - `Mem_Ready`=1: register `Mem_DataIn` into the owner's DataOut (reads only), clear Error, drop the strobes, go to DONE.
  - `TIMEOUT`≠0 and counter == `TIMEOUT`-1 without `Mem_Ready`: drop the strobes, set Error, leave DataOut unchanged, go to DONE.
  - Otherwise increment the counter. The counter is 8 bits and saturates.
- **DONE**
  - Assert the owner's Ready (and Error if set) for exactly one cycle, then go to IDLE.
  - Ready is suppressed, and DataOut is left unchanged, if the owner dropped its request before DONE (for example, a flush). The memory transaction still completes.
- When `DM_Read` and `DM_Write` are both nonzero, the request is treated as a write and `Mem_Read` stays 0.
- A granted transaction always runs to completion. A requester changing address mid-transaction has no effect.
- DataOut registers hold their value until the next successful read for that requester.

## Timing
- Reset values: state IDLE; all `Mem_*` outputs 0; `IF_Ready`, `DM_Ready`, `IF_Error`, `DM_Error` 0; both DataOut registers 0; counter 0. Reset mid-transaction abandons it with no Ready pulse.
- Request sampled in IDLE at cycle 0:
  - Strobes are driven from cycle 1.
  - `Mem_Ready` at cycle 1 gives Ready at cycle 2 and IDLE at cycle 3.
  - Minimum latency is 2 cycles; peak throughput is one access per 3 cycles.
  - Each extra memory wait cycle adds 1 to the latency.
- The requester must advance on the edge that ends its Ready cycle. The request seen in the following IDLE cycle is then treated as new, which prevents re-granting a stale request.
- A timeout produces Ready at cycle `TIMEOUT`+1 after the grant.
- `DM_Stall` has no added latency; it is 0 only in the DM Ready cycle or when DM has no request.

## Test plan
- **Single IF read:** `IF_Read`=1, address 0x10, memory acknowledges after 0 wait cycles with 0x2402_0005 -> `Mem_Read`=1 at cycle 1 with `Mem_Address`=0x10, `IF_Ready`=1 at cycle 2, `IF_DataOut`=0x2402_0005, `IF_Error`=0.
- **Simultaneous requests:** IF and DM read both asserted at cycle 0 -> DM is served first (`DM_Ready` at cycle 2), then IF is granted at cycle 3 with `IF_Ready` at cycle 5. `DM_Stall` is 1 in cycles 0-1 and 0 at cycle 2.
- **Byte write with wait states:** `DM_Write`=4'b0011, data 0xDEAD_BEEF, 3 memory wait cycles -> `Mem_Write`=0011 held for 4 cycles, `DM_Ready` at cycle 5, `DM_DataOut` unchanged.
- **Read+write conflict:** `DM_Read`=1 and `DM_Write`=4'b1111 -> `Mem_Read`=0, `Mem_Write`=1111.
- **Watchdog:** `TIMEOUT`=4, `Mem_Ready` never asserted -> strobes drop after 4 BUSY cycles, `IF_Ready`=1 and `IF_Error`=1 at cycle 5, `IF_DataOut` retains its old value.
- **Flush and reset:** IF drops `IF_Read` during BUSY -> no `IF_Ready` pulse, arbiter back in IDLE 2 cycles after `Mem_Ready`. `reset` during BUSY -> all outputs 0 on the next edge.
